// File: rtl/imm_decode_pkg.sv
// Shared format codes and RISC-V major opcodes for the immediate decode pipeline.
package imm_decode_pkg;

   typedef enum logic [2:0] {
      FMT_R     = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHIFT = 3'd6
   } fmt_e;

   localparam logic [6:0] OP_LOAD     = 7'h03;
   localparam logic [6:0] OP_MISC_MEM = 7'h0F;
   localparam logic [6:0] OP_IMM      = 7'h13;
   localparam logic [6:0] OP_AUIPC    = 7'h17;
   localparam logic [6:0] OP_STORE    = 7'h23;
   localparam logic [6:0] OP_REG      = 7'h33;
   localparam logic [6:0] OP_LUI      = 7'h37;
   localparam logic [6:0] OP_BRANCH   = 7'h63;
   localparam logic [6:0] OP_JALR     = 7'h67;
   localparam logic [6:0] OP_JAL      = 7'h6F;
   localparam logic [6:0] OP_SYSTEM   = 7'h73;

endpackage

// File: rtl/imm_decode_pipe_if.sv
// Valid/ready bundle from the instruction register, through the decoder, to the operand mux.
// master = the surrounding core side, slave = the decoder.
interface imm_decode_pipe_if #(parameter int XLEN = 32);
   import imm_decode_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   fmt_e            out_fmt;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_instr, out_fmt, out_imm, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_instr, out_fmt, out_imm, out_illegal
   );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extraction for an already-classified instruction; sign extension
// always comes from instr[31], shift amounts are zero-extended (6 bits wide at XLEN = 64).
module imm_extract
   import imm_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  fmt_e            fmt,
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   logic [5:0] shamt;
   logic       unused_opcode;

   assign shamt         = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
   assign unused_opcode = ^instr[6:0];

   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I:     imm = XLEN'($signed(instr[31:20]));
         FMT_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         FMT_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         FMT_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         FMT_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
         FMT_SHIFT: imm = XLEN'(shamt);
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/imm_decode_pipe.sv
// Two-stage immediate decoder: stage 1 classifies the opcode, stage 2 holds the extended immediate.
// Stalls hold both stages; IMM_DECODE_ILLEGAL_EN enables out_illegal for unknown opcodes.
module imm_decode_pipe
   import imm_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   imm_decode_pipe_if.slave  bus
);

   logic            adv1;
   logic            adv2;
   fmt_e            dec_fmt;
   logic            dec_unknown;
   logic            dec_illegal;
   logic [2:0]      funct3;

   logic            s1_valid;
   logic [31:0]     s1_instr;
   fmt_e            s1_fmt;
   logic            s1_illegal;
   logic [XLEN-1:0] s1_imm;

   logic            s2_valid;
   logic [31:0]     s2_instr;
   fmt_e            s2_fmt;
   logic [XLEN-1:0] s2_imm;
   logic            s2_illegal;

   assign adv2         = !s2_valid || bus.out_ready;
   assign adv1         = !s1_valid || adv2;
   assign bus.in_ready = adv1 && !flush && !rst;
   assign funct3       = bus.in_instr[14:12];

   always_comb begin
      dec_fmt     = FMT_R;
      dec_unknown = 1'b0;
      case (bus.in_instr[6:0])
         OP_LOAD, OP_MISC_MEM, OP_JALR, OP_SYSTEM: dec_fmt = FMT_I;
         OP_IMM:    dec_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHIFT : FMT_I;
         OP_AUIPC, OP_LUI: dec_fmt = FMT_U;
         OP_STORE:  dec_fmt = FMT_S;
         OP_REG:    dec_fmt = FMT_R;
         OP_BRANCH: dec_fmt = FMT_B;
         OP_JAL:    dec_fmt = FMT_J;
         default:   dec_unknown = 1'b1;
      endcase
   end

   // Every listed opcode ends in 2'b11, so the opcode match also covers instr[1:0].
`ifdef IMM_DECODE_ILLEGAL_EN
   assign dec_illegal = dec_unknown;
`else
   logic unused_unknown;
   assign unused_unknown = dec_unknown;
   assign dec_illegal    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_instr   <= '0;
         s1_fmt     <= FMT_R;
         s1_illegal <= 1'b0;
      end else if (flush) begin
         s1_valid   <= 1'b0;
      end else if (adv1) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_instr   <= bus.in_instr;
            s1_fmt     <= dec_fmt;
            s1_illegal <= dec_illegal;
         end
      end
   end

   imm_extract #(.XLEN(XLEN)) u_extract (
      .fmt   (s1_fmt),
      .instr (s1_instr),
      .imm   (s1_imm)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         s2_instr   <= '0;
         s2_fmt     <= FMT_R;
         s2_imm     <= '0;
         s2_illegal <= 1'b0;
      end else if (flush) begin
         s2_valid   <= 1'b0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_instr   <= s1_instr;
            s2_fmt     <= s1_fmt;
            s2_imm     <= s1_imm;
            s2_illegal <= s1_illegal;
         end
      end
   end

   assign bus.out_valid   = s2_valid;
   assign bus.out_instr   = s2_instr;
   assign bus.out_fmt     = s2_fmt;
   assign bus.out_imm     = s2_imm;
   assign bus.out_illegal = s2_illegal;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench for imm_decode_pipe: hand-computed vectors through a 32-bit instance
// plus a 64-bit instance for the XLEN-dependent U and SHIFT cases.
module tb_imm_decode_pipe;
   import imm_decode_pkg::*;

`ifdef IMM_DECODE_ILLEGAL_EN
   localparam logic ILL = 1'b1;
`else
   localparam logic ILL = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [31:0] imm;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   always #5 clk = ~clk;

   imm_decode_pipe_if #(.XLEN(32)) bus32 ();
   imm_decode_pipe_if #(.XLEN(64)) bus64 ();

   imm_decode_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32));
   imm_decode_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));

   int   vec_cnt = 0;
   int   err_cnt = 0;
   exp_t sb[$];
   exp_t mon_e;
   exp_t tbl[18];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] i, input fmt_e f, input logic [31:0] imm,
                               input logic ill);
      exp_t e;
      e.instr = i;
      e.fmt   = f;
      e.imm   = imm;
      e.ill   = ill;
      return e;
   endfunction

   // Scoreboard: every completed output transfer must match the oldest accepted instruction.
   always @(negedge clk) begin
      if (!rst && bus32.out_valid && bus32.out_ready) begin
         if (sb.size() == 0) begin
            chk("spurious_out_valid", 64'(bus32.out_valid), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("out_instr",   64'(bus32.out_instr),   64'(mon_e.instr));
            chk("out_fmt",     64'(bus32.out_fmt),     64'(mon_e.fmt));
            chk("out_imm",     64'(bus32.out_imm),     64'(mon_e.imm));
            chk("out_illegal", 64'(bus32.out_illegal), 64'(mon_e.ill));
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted e.
   task automatic send(input exp_t e);
      int t = 0;
      bus32.in_valid = 1'b1;
      bus32.in_instr = e.instr;
      @(negedge clk);
      while (!bus32.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("send_accept", 64'(bus32.in_ready), 64'd1);
      if (bus32.in_ready) sb.push_back(e);
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (sb.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"},   64'(bus32.out_valid),   64'd0);
      chk({tag, "_out_imm"},     64'(bus32.out_imm),     64'd0);
      chk({tag, "_out_instr"},   64'(bus32.out_instr),   64'd0);
      chk({tag, "_out_fmt"},     64'(bus32.out_fmt),     64'(FMT_R));
      chk({tag, "_out_illegal"}, 64'(bus32.out_illegal), 64'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl = '{
         mk(32'h01F09093, FMT_SHIFT, 32'h0000001F, 1'b0),  // slli x1,x1,31
         mk(32'hFE000EE3, FMT_B,     32'hFFFFFFFC, 1'b0),  // beq -4
         mk(32'h001000EF, FMT_J,     32'h00000800, 1'b0),  // jal +2048
         mk(32'h123452B7, FMT_U,     32'h12345000, 1'b0),  // lui
         mk(32'h800002B7, FMT_U,     32'h80000000, 1'b0),  // lui, negative
         mk(32'hFE112E23, FMT_S,     32'hFFFFFFFC, 1'b0),  // sw -4
         mk(32'h002081B3, FMT_R,     32'h00000000, 1'b0),  // add
         mk(32'h4050D093, FMT_SHIFT, 32'h00000005, 1'b0),  // srai 5
         mk(32'h03F09093, FMT_SHIFT, 32'h0000001F, 1'b0),  // slli, instr[25] ignored at 32
         mk(32'h0FF0F093, FMT_I,     32'h000000FF, 1'b0),  // andi, funct3 111
         mk(32'hFFFFF517, FMT_U,     32'hFFFFF000, 1'b0),  // auipc
         mk(32'h00000073, FMT_I,     32'h00000000, 1'b0),  // ecall
         mk(32'h00812083, FMT_I,     32'h00000008, 1'b0),  // lw 8
         mk(32'h000080E7, FMT_I,     32'h00000000, 1'b0),  // jalr
         mk(32'h0FF0000F, FMT_I,     32'h000000FF, 1'b0),  // fence
         mk(32'hFFDFF06F, FMT_J,     32'hFFFFFFFC, 1'b0),  // jal -4
         mk(32'h0000007F, FMT_R,     32'h00000000, ILL),   // unknown opcode
         mk(32'h00000001, FMT_R,     32'h00000000, ILL)    // instr[1:0] != 11
      };

      rst   = 1'b1;
      flush = 1'b0;
      bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.out_ready = 1'b1;
      bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(bus32.in_ready), 64'd0);
      chk_reset_vals("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(bus32.in_ready), 64'd1);
      @(posedge clk); #1;

      // Two-stage latency: addi accepted at edge N is visible after edge N+1.
      bus32.in_valid = 1'b1;
      bus32.in_instr = 32'hFFF00093;
      sb.push_back(mk(32'hFFF00093, FMT_I, 32'hFFFFFFFF, 1'b0));
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      @(negedge clk);
      chk("lat_after_n", 64'(bus32.out_valid), 64'd0);
      @(negedge clk);
      chk("lat_after_n1", 64'(bus32.out_valid), 64'd1);
      @(posedge clk); #1;

      // Back-to-back: one result per cycle.
      send(tbl[0]); send(tbl[1]); send(tbl[2]);
      @(negedge clk); chk("b2b_second", 64'(bus32.out_valid), 64'd1);
      @(negedge clk); chk("b2b_third",  64'(bus32.out_valid), 64'd1);
      @(negedge clk); chk("b2b_empty",  64'(bus32.out_valid), 64'd0);
      @(posedge clk); #1;
      for (int i = 3; i < 18; i++) send(tbl[i]);
      drain("drain_table");

      // XLEN = 64: bit 31 replicated for U, 6-bit shamt for SHIFT.
      bus64.in_valid = 1'b1; bus64.in_instr = 32'h800002B7;
      @(posedge clk); #1;
      bus64.in_instr = 32'h03F09093;
      @(posedge clk); #1;
      bus64.in_valid = 1'b0;
      @(negedge clk);
      chk("x64_lui_valid", 64'(bus64.out_valid), 64'd1);
      chk("x64_lui_fmt",   64'(bus64.out_fmt),   64'(FMT_U));
      chk("x64_lui_imm",   bus64.out_imm,        64'hFFFFFFFF80000000);
      @(negedge clk);
      chk("x64_slli_fmt",  64'(bus64.out_fmt),   64'(FMT_SHIFT));
      chk("x64_slli_imm",  bus64.out_imm,        64'h000000000000003F);
      @(posedge clk); #1;

      // Stall: three offered with out_ready low; only two fit.
      bus32.out_ready = 1'b0;
      send(tbl[3]); send(tbl[5]);
      bus32.in_valid = 1'b1;
      bus32.in_instr = tbl[1].instr;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_in_ready",  64'(bus32.in_ready),  64'd0);
         chk("stall_out_valid", 64'(bus32.out_valid), 64'd1);
         chk("stall_out_instr", 64'(bus32.out_instr), 64'(tbl[3].instr));
         chk("stall_out_imm",   64'(bus32.out_imm),   64'(tbl[3].imm));
         @(posedge clk); #1;
      end
      bus32.out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 64'(bus32.in_ready), 64'd1);
      if (bus32.in_ready) sb.push_back(tbl[1]);
      @(posedge clk); #1;
      bus32.in_valid = 1'b0;
      drain("drain_stall");

      // Flush with both stages full: the head output still completes, the rest is dropped.
      bus32.out_ready = 1'b0;
      send(tbl[0]); send(tbl[1]);
      bus32.out_ready = 1'b1;
      bus32.in_valid  = 1'b1;
      bus32.in_instr  = tbl[2].instr;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 64'(bus32.in_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      bus32.in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("flush_out_valid", 64'(bus32.out_valid), 64'd0);
      chk("flush_in_ready_after", 64'(bus32.in_ready), 64'd1);
      @(negedge clk);
      chk("flush_s1_empty", 64'(bus32.out_valid), 64'd0);
      @(posedge clk); #1;
      send(tbl[15]);
      drain("drain_flush");

      // Reset mid-stream discards everything in flight.
      send(tbl[3]); send(tbl[4]);
      rst = 1'b1;
      bus32.in_valid = 1'b1;
      bus32.in_instr = tbl[6].instr;
      @(negedge clk);
      chk("mid_rst_in_ready", 64'(bus32.in_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus32.in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      chk_reset_vals("mid_rst");
      chk("mid_rst_in_ready_after", 64'(bus32.in_ready), 64'd1);
      @(negedge clk);
      chk("mid_rst_s1_empty", 64'(bus32.out_valid), 64'd0);
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
